// File: rtl/sticker_color_capture.sv
// sticker_color_capture: debounces the classified colour stream and writes stable colours into a 9-slot face register.
module sticker_color_capture #(
    parameter int SAMPLE_DIV   = 65000,
    parameter int STABLE_COUNT = 8,
    parameter int MAX_SAMPLES  = 255,
    parameter int NUM_STICKERS = 9
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [2:0]                color_in,
    input  logic                      sensor_ready,
    input  logic                      capture_req,
    input  logic [3:0]                sticker_index,
    input  logic                      face_clear,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout,
    output logic                      index_error,
    output logic [2:0]                color_out,
    output logic [3*NUM_STICKERS-1:0] face,
    output logic [NUM_STICKERS-1:0]   face_valid,
    output logic                      face_complete
);
    localparam int TW = $clog2(SAMPLE_DIV);
    localparam int RW = $clog2(STABLE_COUNT + 1);
    localparam int SW = $clog2(MAX_SAMPLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [RW-1:0] RUN_MAX   = RW'(STABLE_COUNT);
    localparam logic [SW-1:0] SMP_MAX   = SW'(MAX_SAMPLES);
    localparam logic [4:0]    NUM5      = 5'(NUM_STICKERS);

    typedef enum logic [2:0] {IDLE, WAIT_READY, SAMPLE, DONE_S, TIMEOUT_S} state_t;

    state_t          state, next_state;
    logic [TW-1:0]   tick_cnt;
    logic [RW-1:0]   run_len, run_next;
    logic [SW-1:0]   sample_cnt, smp_next;
    logic [2:0]      cand;
    logic [3:0]      idx_q;
    logic            tick, no_match, same, accept, expire, idx_ok, start;

    assign face_complete = &face_valid;

    always_comb begin
        tick     = state == SAMPLE && sensor_ready && tick_cnt == TICK_LAST;
        no_match = &color_in[2:1];
        same     = color_in == cand && run_len != '0;
        run_next = no_match ? '0 : same ? run_len + 1'b1 : RW'(1);
        smp_next = sample_cnt + 1'b1;
        accept   = run_next == RUN_MAX;
        expire   = smp_next == SMP_MAX;
        idx_ok   = {1'b0, sticker_index} < NUM5;
        start    = state == IDLE && capture_req && idx_ok;
        next_state = (state == IDLE)       ? (start ? (sensor_ready ? SAMPLE : WAIT_READY) : IDLE)
                   : (state == WAIT_READY) ? (sensor_ready ? SAMPLE : WAIT_READY)
                   : (state == SAMPLE)     ? (!sensor_ready ? WAIT_READY : !tick ? SAMPLE
                                             : accept ? DONE_S : expire ? TIMEOUT_S : SAMPLE)
                   : IDLE;
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            index_error <= 1'b0;
            color_out   <= '0;
            face        <= '0;
            face_valid  <= '0;
            tick_cnt    <= '0;
            run_len     <= '0;
            sample_cnt  <= '0;
            cand        <= '0;
            idx_q       <= '0;
        end else begin
            done        <= state == DONE_S;
            timeout     <= state == TIMEOUT_S;
            index_error <= state == IDLE && capture_req && !idx_ok;
            busy        <= start ? 1'b1 : (state == DONE_S || state == TIMEOUT_S) ? 1'b0 : busy;
            if (start) idx_q <= sticker_index;
            // Clear precedes a same-cycle request; the slot write only happens much later.
            if (state == IDLE && face_clear) begin
                face       <= '0;
                face_valid <= '0;
            end
            if (state == DONE_S) begin
                face[3*idx_q +: 3] <= cand;
                face_valid[idx_q]  <= 1'b1;
                color_out          <= cand;
            end
            if (start || (state == SAMPLE && !sensor_ready)) begin
                tick_cnt   <= '0;
                run_len    <= '0;
                sample_cnt <= '0;
            end else if (state == SAMPLE) begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                if (tick) begin
                    run_len    <= run_next;
                    sample_cnt <= smp_next;
                    if (!no_match) cand <= color_in;
                end
            end
        end
    end
endmodule

// File: tb/tb_sticker_color_capture.sv
// tb_sticker_color_capture: scoreboard bench for sticker_color_capture with a shortened sample period.
module tb_sticker_color_capture;
    localparam int SD = 4, SC = 3, MS = 10, NS = 9;
    localparam int K_DONE = 1, K_TOUT = 2, K_IERR = 3;

    logic        clock = 1'b0, reset = 1'b0;
    logic [2:0]  color_in = 3'd0;
    logic        sensor_ready = 1'b1, capture_req = 1'b0, face_clear = 1'b0;
    logic [3:0]  sticker_index = 4'd0;
    logic        busy, done, timeout, index_error, face_complete;
    logic [2:0]  color_out;
    logic [26:0] face;
    logic [8:0]  face_valid;

    int checks = 0, failures = 0;
    typedef struct {int kind; int cyc; logic [2:0] color;} exp_t;
    exp_t sb[$];
    logic [26:0] face_m = '0;
    logic [8:0]  valid_m = '0;

    sticker_color_capture #(.SAMPLE_DIV(SD), .STABLE_COUNT(SC), .MAX_SAMPLES(MS), .NUM_STICKERS(NS)) dut (
        .clock(clock), .reset(reset), .color_in(color_in), .sensor_ready(sensor_ready),
        .capture_req(capture_req), .sticker_index(sticker_index), .face_clear(face_clear),
        .busy(busy), .done(done), .timeout(timeout), .index_error(index_error),
        .color_out(color_out), .face(face), .face_valid(face_valid), .face_complete(face_complete));

    always #5 clock = ~clock;

    task automatic request(input logic [3:0] idx, input int kind, input int cyc, input logic [2:0] col);
        exp_t e;
        e.kind = kind; e.cyc = cyc; e.color = col;
        sb.push_back(e);
        sticker_index = idx;
        capture_req = 1'b1;
    endtask

    task automatic wait_evt(output int kind, output int cyc);
        kind = 0; cyc = 0;
        while (kind == 0 && cyc < 400) begin
            @(posedge clock);
            cyc++;
            #1 capture_req = 1'b0;
            @(negedge clock);
            kind = done ? K_DONE : timeout ? K_TOUT : index_error ? K_IERR : 0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({busy, done, timeout, index_error, color_out, face, face_valid, face_complete} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b face=%h valid=%h, required all zero", busy, done, face, face_valid);
        end
        @(posedge clock); #1 reset = 1'b1;
    endtask

    task automatic test_steady();
        int kind, cyc, b;
        exp_t e;
        @(posedge clock); #1;
        color_in = 3'd2;
        request(4'd4, K_DONE, 14, 3'd2);
        fork
            wait_evt(kind, cyc);
            begin repeat (2) @(posedge clock); @(negedge clock); b = busy; end
        join
        e = sb.pop_front();
        face_m[14:12] = 3'd2; valid_m[4] = 1'b1;
        checks++;
        if (kind !== e.kind || cyc !== e.cyc) begin
            failures++;
            $display("FAIL steady_event: got kind=%0d cyc=%0d, required kind=%0d cyc=%0d", kind, cyc, e.kind, e.cyc);
        end
        checks++;
        if (b !== 1) begin failures++; $display("FAIL steady_busy_mid: got %0d, required 1", b); end
        checks++;
        if (face[14:12] !== e.color || face_valid !== 9'h010 || color_out !== e.color) begin
            failures++;
            $display("FAIL steady_write: got slot=%0d valid=%h color=%0d, required slot=%0d valid=010 color=%0d", face[14:12], face_valid, color_out, e.color, e.color);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL steady_after: got busy=%b done=%b, required 0 0", busy, done); end
    endtask

    task automatic test_flicker();
        int kind, cyc;
        logic [2:0] seq [5] = '{3'd1, 3'd1, 3'd3, 3'd3, 3'd3};
        exp_t e;
        @(posedge clock); #1;
        color_in = seq[0];
        request(4'd5, K_DONE, 22, 3'd3);
        fork
            wait_evt(kind, cyc);
            begin
                repeat (5) @(posedge clock);
                #1 color_in = seq[1];
                for (int k = 2; k < 5; k++) begin repeat (4) @(posedge clock); #1 color_in = seq[k]; end
            end
            begin repeat (7) @(posedge clock); #1 face_clear = 1'b1; @(posedge clock); #1 face_clear = 1'b0; end
        join
        e = sb.pop_front();
        face_m[17:15] = 3'd3; valid_m[5] = 1'b1;
        checks++;
        if (kind !== e.kind || cyc !== e.cyc || color_out !== e.color) begin
            failures++;
            $display("FAIL flicker_event: got kind=%0d cyc=%0d color=%0d, required kind=%0d cyc=%0d color=%0d", kind, cyc, color_out, e.kind, e.cyc, e.color);
        end
        checks++;
        if (face !== face_m || face_valid !== valid_m) begin
            failures++;
            $display("FAIL flicker_face: got face=%h valid=%h, required face=%h valid=%h", face, face_valid, face_m, valid_m);
        end
    endtask

    task automatic test_no_match();
        int kind, cyc;
        exp_t e;
        @(posedge clock); #1;
        color_in = 3'd7;
        request(4'd6, K_TOUT, 42, 3'd3);
        wait_evt(kind, cyc);
        e = sb.pop_front();
        checks++;
        if (kind !== e.kind || cyc !== e.cyc) begin
            failures++;
            $display("FAIL timeout_event: got kind=%0d cyc=%0d, required kind=%0d cyc=%0d", kind, cyc, e.kind, e.cyc);
        end
        checks++;
        if (face !== face_m || face_valid !== valid_m || busy !== 1'b0 || color_out !== e.color) begin
            failures++;
            $display("FAIL timeout_state: got face=%h valid=%h busy=%b color=%0d, required face=%h valid=%h busy=0 color=%0d", face, face_valid, busy, color_out, face_m, valid_m, e.color);
        end
    endtask

    task automatic test_invalid_index();
        int kind, cyc;
        exp_t e;
        @(posedge clock); #1;
        color_in = 3'd1;
        request(4'd9, K_IERR, 1, 3'd0);
        wait_evt(kind, cyc);
        e = sb.pop_front();
        checks++;
        if (kind !== e.kind || cyc !== e.cyc || busy !== 1'b0) begin
            failures++;
            $display("FAIL index_error: got kind=%0d cyc=%0d busy=%b, required kind=%0d cyc=%0d busy=0", kind, cyc, busy, e.kind, e.cyc);
        end
        repeat (20) @(posedge clock);
        @(negedge clock);
        checks++;
        if (face_valid !== valid_m || busy !== 1'b0) begin
            failures++;
            $display("FAIL index_nowrite: got valid=%h busy=%b, required valid=%h busy=0", face_valid, busy, valid_m);
        end
    endtask

    task automatic test_ready_drop();
        int kind, cyc;
        exp_t e;
        @(posedge clock); #1;
        color_in = 3'd5;
        request(4'd0, K_DONE, 28, 3'd5);
        fork
            wait_evt(kind, cyc);
            begin
                repeat (9) @(posedge clock); #1 sensor_ready = 1'b0;
                repeat (5) @(posedge clock); #1 sensor_ready = 1'b1;
            end
        join
        e = sb.pop_front();
        face_m[2:0] = 3'd5; valid_m[0] = 1'b1;
        checks++;
        if (kind !== e.kind || cyc !== e.cyc || color_out !== e.color) begin
            failures++;
            $display("FAIL ready_drop: got kind=%0d cyc=%0d color=%0d, required kind=%0d cyc=%0d color=%0d", kind, cyc, color_out, e.kind, e.cyc, e.color);
        end
    endtask

    task automatic test_fill_clear();
        int kind, cyc, bad;
        exp_t e;
        bad = 0;
        for (int i = 0; i < NS; i++) begin
            @(posedge clock); #1;
            color_in = 3'(i % 6);
            request(4'(i), K_DONE, 14, 3'(i % 6));
            wait_evt(kind, cyc);
            e = sb.pop_front();
            face_m[3*i +: 3] = e.color; valid_m[i] = 1'b1;
            checks++;
            if (kind !== e.kind || cyc !== e.cyc || color_out !== e.color) begin
                failures++;
                $display("FAIL fill_slot%0d: got kind=%0d cyc=%0d color=%0d, required kind=%0d cyc=%0d color=%0d", i, kind, cyc, color_out, e.kind, e.cyc, e.color);
            end
        end
        checks++;
        if (face !== face_m || face_valid !== 9'h1ff || face_complete !== 1'b1) begin
            failures++;
            $display("FAIL fill_face: got face=%h valid=%h complete=%b, required face=%h valid=1ff complete=1", face, face_valid, face_complete, face_m);
        end
        @(posedge clock); #1 face_clear = 1'b1;
        @(posedge clock); #1 face_clear = 1'b0;
        @(negedge clock);
        face_m = '0; valid_m = '0;
        checks++;
        if (face !== face_m || face_valid !== valid_m || face_complete !== 1'b0) begin
            failures++;
            $display("FAIL clear: got face=%h valid=%h complete=%b, required 0 0 0", face, face_valid, face_complete);
        end
    endtask

    task automatic test_reset_mid();
        int kind, cyc;
        exp_t e;
        @(posedge clock); #1;
        color_in = 3'd3;
        request(4'd1, K_DONE, 14, 3'd3);
        wait_evt(kind, cyc);
        e = sb.pop_front();
        checks++;
        if (kind !== e.kind || cyc !== e.cyc || face[5:3] !== e.color) begin
            failures++;
            $display("FAIL pre_reset_capture: got kind=%0d cyc=%0d slot=%0d, required kind=%0d cyc=%0d slot=%0d", kind, cyc, face[5:3], e.kind, e.cyc, e.color);
        end
        @(posedge clock); #1;
        color_in = 3'd4;
        sticker_index = 4'd2; capture_req = 1'b1;
        @(posedge clock); #1 capture_req = 1'b0;
        repeat (9) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({busy, done, timeout, index_error, color_out, face, face_valid, face_complete} !== '0) begin
            failures++;
            $display("FAIL reset_mid: got busy=%b color=%0d face=%h valid=%h, required all zero", busy, color_out, face, face_valid);
        end
        repeat (20) @(posedge clock);
        @(negedge clock);
        checks++;
        if (face_valid !== 9'h000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_nowrite: got valid=%h busy=%b, required 000 0", face_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_flicker();
        test_no_match();
        test_invalid_index();
        test_ready_drop();
        test_fill_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
